// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl
//   Time-shares one DATAW-bit (byte-lane) S-box between a block requester
//   (SubBytes over WORDS words) and a key-schedule requester (SubWord).
//   The S-box itself lives outside; this block drives its input, captures
//   its combinational output and returns results over valid/ready.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   blk_valid_i/blk_ready_o  block request handshake, blk_data_i payload
//   blk_valid_o/blk_ready_i  block result handshake, blk_data_o payload
//   key_valid_i/key_ready_o  key-word request handshake, key_data_i payload
//   key_valid_o/key_ready_i  key-word result handshake, key_data_o payload
//   sbox_data_o/sbox_data_i  to / from the shared S-box
//   busy_o                   high whenever the sequencer is not idle
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitrating; the only state in which requests are accepted
// BLK_SUB | one block word per cycle through the S-box, index 0..WORDS-1
// BLK_OUT | block result presented, waiting for blk_ready_i
// KEY_SUB | key word through the S-box (single cycle)
// KEY_OUT | key result presented, waiting for key_ready_i
module sbox_share_ctrl #(
  parameter int DATAW = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [WORDS*DATAW-1:0] blk_data_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [WORDS*DATAW-1:0] blk_data_o,
  input  logic                   key_valid_i,
  output logic                   key_ready_o,
  input  logic [DATAW-1:0]       key_data_i,
  output logic                   key_valid_o,
  input  logic                   key_ready_i,
  output logic [DATAW-1:0]       key_data_o,
  output logic [DATAW-1:0]       sbox_data_o,
  input  logic [DATAW-1:0]       sbox_data_i,
  output logic                   busy_o
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLK_SUB = 3'd1,
    BLK_OUT = 3'd2,
    KEY_SUB = 3'd3,
    KEY_OUT = 3'd4
  } state_e;

  state_e                        state_q;
  logic [IDXW-1:0]               idx_q;
  logic                          last_key_q;
  logic [WORDS-1:0][DATAW-1:0]   blk_in_q;
  logic [WORDS-1:0][DATAW-1:0]   blk_res_q;
  logic [DATAW-1:0]              key_in_q;
  logic [DATAW-1:0]              key_res_q;
  logic                          blk_valid_q;
  logic                          key_valid_q;
  logic                          idle;

  assign idle = (state_q == IDLE);

  // On a tie the requester that was not served last wins; a lone
  // requester always gets through.
  assign blk_ready_o = idle && (!key_valid_i || last_key_q);
  assign key_ready_o = idle && (!blk_valid_i || !last_key_q);

  assign blk_valid_o = blk_valid_q;
  assign key_valid_o = key_valid_q;
  assign blk_data_o  = blk_res_q;
  assign key_data_o  = key_res_q;
  assign busy_o      = !idle;

  always_comb begin
    sbox_data_o = '0;
    case (state_q)
      BLK_SUB: sbox_data_o = blk_in_q[idx_q];
      KEY_SUB: sbox_data_o = key_in_q;
      default: sbox_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_key_q  <= 1'b0;
      blk_in_q    <= '0;
      blk_res_q   <= '0;
      key_in_q    <= '0;
      key_res_q   <= '0;
      blk_valid_q <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // At most one of the two grants can be active in a cycle.
          if (key_valid_i && key_ready_o) begin
            key_in_q   <= key_data_i;
            last_key_q <= 1'b1;
            state_q    <= KEY_SUB;
          end else if (blk_valid_i && blk_ready_o) begin
            blk_in_q   <= blk_data_i;
            idx_q      <= '0;
            last_key_q <= 1'b0;
            state_q    <= BLK_SUB;
          end
        end
        BLK_SUB: begin
          blk_res_q[idx_q] <= sbox_data_i;
          if (idx_q == IDX_LAST) begin
            idx_q       <= '0;
            blk_valid_q <= 1'b1;
            state_q     <= BLK_OUT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        BLK_OUT: begin
          if (blk_ready_i) begin
            blk_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        KEY_SUB: begin
          key_res_q   <= sbox_data_i;
          key_valid_q <= 1'b1;
          state_q     <= KEY_OUT;
        end
        KEY_OUT: begin
          if (key_ready_i) begin
            key_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
module tb_sbox_share_ctrl;

  localparam int DATAW = 32;
  localparam int WORDS = 4;
  localparam int BW    = WORDS * DATAW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          blk_valid_i = 1'b0;
  logic          blk_ready_o;
  logic [BW-1:0] blk_data_i = '0;
  logic          blk_valid_o;
  logic          blk_ready_i = 1'b1;
  logic [BW-1:0] blk_data_o;
  logic          key_valid_i = 1'b0;
  logic          key_ready_o;
  logic [31:0]   key_data_i = '0;
  logic          key_valid_o;
  logic          key_ready_i = 1'b1;
  logic [31:0]   key_data_o;
  logic [31:0]   sbox_data_o;
  logic [31:0]   sbox_data_i;
  logic          busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  sbox_share_ctrl #(.DATAW(DATAW), .WORDS(WORDS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
    .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .key_data_i(key_data_i),
    .key_valid_o(key_valid_o), .key_ready_i(key_ready_i), .key_data_o(key_data_o),
    .sbox_data_o(sbox_data_o), .sbox_data_i(sbox_data_i), .busy_o(busy_o)
  );

  // AES forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  always_comb begin
    sbox_data_i = '0;
    for (int b = 0; b < 4; b++) sbox_data_i[b*8 +: 8] = sb(sbox_data_o[b*8 +: 8]);
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge, measure latency to result valid,
  // check data, and check return to idle after the handshake.
  task automatic run_req(input string name, input bit is_key, input logic [BW-1:0] din,
                         input logic [BW-1:0] dexp, input int lat_exp);
    int n;
    if (is_key) begin key_data_i = din[31:0]; key_valid_i = 1'b1; end
    else begin blk_data_i = din; blk_valid_i = 1'b1; end
    #1;
    n = 0;
    while (!(is_key ? key_ready_o : blk_ready_o) && n < 20) begin @(negedge clk_i); n++; end
    check({name, "_accept_wait"}, BW'(n), BW'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    blk_valid_i = 1'b0;
    n = 1;
    while (!(is_key ? key_valid_o : blk_valid_o) && n < 20) begin @(negedge clk_i); n++; end
    check({name, "_latency"}, BW'(n), BW'(lat_exp));
    check({name, "_data"}, is_key ? BW'(key_data_o) : blk_data_o, dexp);
    @(negedge clk_i);
    check({name, "_idle_after"}, BW'({busy_o, blk_valid_o, key_valid_o}), BW'(0));
  endtask

  typedef struct {
    string         name;
    bit            is_key;
    logic [BW-1:0] din;
    logic [BW-1:0] dexp;
    int            lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt, idle_run, max_idle, both, highs;
    bit grants[$];
    logic [BW-1:0] held;

    vecs[0] = '{"blk_seq", 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                128'h637c777bf26b6fc53001672bfed7ab76, 5};
    vecs[1] = '{"key_53ff", 1'b1, 128'h53ff0001, 128'hed16637c, 2};
    vecs[2] = '{"blk_zero", 1'b0, 128'h0, {16{8'h63}}, 5};
    vecs[3] = '{"key_zero", 1'b1, 128'h0, 128'h63636363, 2};
    vecs[4] = '{"blk_ones", 1'b0, {16{8'hff}}, {16{8'h16}}, 5};
    vecs[5] = '{"key_ones", 1'b1, 128'hffffffff, 128'h16161616, 2};
    vecs[6] = '{"blk_row1", 1'b0, 128'h101112131415161718191a1b1c1d1e1f,
                128'hca82c97dfa5947f0add4a2af9ca472c0, 5};

    // Reset, then idle
    repeat (3) @(negedge clk_i);
    check("rst_outputs", BW'({blk_valid_o, key_valid_o, busy_o, sbox_data_o, key_data_o}), BW'(0));
    check("rst_blk_data", blk_data_o, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_readies", BW'({blk_ready_o, key_ready_o, busy_o}), BW'(3'b110));

    for (int i = 0; i < 7; i++) run_req(vecs[i].name, vecs[i].is_key, vecs[i].din, vecs[i].dexp, vecs[i].lat);

    // Tie arbitration from reset
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    blk_data_i = 128'h0;
    key_data_i = 32'h0;
    blk_valid_i = 1'b1;
    key_valid_i = 1'b1;
    idle_run = 0; max_idle = 0; both = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (key_ready_o && blk_ready_o) both++;
      if (key_ready_o) grants.push_back(1'b1);
      else if (blk_ready_o) grants.push_back(1'b0);
      if (!busy_o) begin idle_run++; if (idle_run > max_idle) max_idle = idle_run; end
      else idle_run = 0;
      @(negedge clk_i);
    end
    blk_valid_i = 1'b0;
    key_valid_i = 1'b0;
    check("arb_both_ready", BW'(both), BW'(0));
    check("arb_max_idle", BW'(max_idle), BW'(1));
    gcnt = grants.size();
    check("arb_grant_count", BW'(gcnt >= 6), BW'(1));
    for (int g = 0; g < 6; g++)
      if (g < gcnt) check($sformatf("arb_grant%0d", g), BW'(grants[g]), BW'((g % 2) == 0));
    repeat (10) @(negedge clk_i);
    check("arb_drained", BW'(busy_o), BW'(0));

    // Backpressure on block result
    blk_ready_i = 1'b0;
    blk_data_i = 128'h000102030405060708090a0b0c0d0e0f;
    blk_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    blk_valid_i = 1'b0;
    highs = 0;
    while (!blk_valid_o && highs < 20) begin @(negedge clk_i); highs++; end
    held = 128'h637c777bf26b6fc53001672bfed7ab76;
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      if (blk_valid_o && blk_data_o == held && !key_ready_o && busy_o) highs++;
      @(negedge clk_i);
    end
    check("bp_held_cycles", BW'(highs), BW'(10));
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_idle", BW'({busy_o, blk_valid_o, blk_ready_o, key_ready_o}), BW'(4'b0011));
    check("bp_data_kept", blk_data_o, held);

    // Reset during BLK_SUB at index 2
    blk_data_i = 128'h000102030405060708090a0b0c0d0e0f;
    blk_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    blk_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("mid_sbox_word2", BW'(sbox_data_o), BW'(32'h04050607));
    rst_ni = 1'b0;
    #1;
    check("mid_rst_outputs", BW'({busy_o, blk_valid_o, key_valid_o, sbox_data_o, key_data_o}), BW'(0));
    check("mid_rst_blk_data", blk_data_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (blk_valid_o || busy_o) highs++;
    end
    check("mid_rst_no_result", BW'(highs), BW'(0));
    run_req("post_rst_blk", 1'b0, 128'h101112131415161718191a1b1c1d1e1f,
            128'hca82c97dfa5947f0add4a2af9ca472c0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbox_share_ctrl.md
Name: sbox_share_ctrl

Overview:
Sequencer and arbiter that time-shares one 32-bit, 4-byte-lane S-box instance between two requesters. The cipher datapath requests 128-bit block substitution (SubBytes). The key schedule requests single-word substitution (SubWord). The block holds no S-box logic itself: it drives the S-box input, captures its combinational output, and returns results through valid/ready handshakes.

Parameters:
DATAW, 32, width of the shared S-box lane in bits (multiple of 8)
WORDS, 4, DATAW-bit words per block request (block width = WORDS*DATAW)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, asynchronous assert, active-low
blk_valid_i  in  1  block request valid
blk_ready_o  out  1  block request accepted when high with blk_valid_i
blk_data_i  in  WORDS*DATAW  block to substitute
blk_valid_o  out  1  block result valid
blk_ready_i  in  1  block result consumed
blk_data_o  out  WORDS*DATAW  substituted block
key_valid_i  in  1  key-word request valid
key_ready_o  out  1  key-word request accepted
key_data_i  in  DATAW  word to substitute
key_valid_o  out  1  key-word result valid
key_ready_i  in  1  key-word result consumed
key_data_o  out  DATAW  substituted word
sbox_data_o  out  DATAW  to shared S-box input
sbox_data_i  in  DATAW  from shared S-box output (combinational)
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_ni low): state=IDLE, word index=0, last_key=0; all data registers and outputs 0. Reset mid-operation discards the request in flight and its result.
- States:
  - IDLE
  - BLK_SUB: one word per cycle, index 0..WORDS-1
  - BLK_OUT
  - KEY_SUB: one cycle
  - KEY_OUT
- Arbitration, IDLE only:
  - blk_ready_o = IDLE && (!key_valid_i || last_key)
  - key_ready_o = IDLE && (!blk_valid_i || !last_key)
  - Both ready are 0 in every other state. No request preempts an operation in progress.
  - last_key is set on key accept and cleared on block accept. Ties therefore alternate, with key first after reset. A single requester is never blocked by an idle peer.
- Block path:
  - Accept at cycle T: blk_data_i is registered, index cleared, go to BLK_SUB.
  - Cycles T+1..T+WORDS: sbox_data_o = word[index], word 0 = bits [DATAW-1:0]. sbox_data_i is written into the matching result word; index increments.
  - After the last word, go to BLK_OUT; blk_valid_o rises at T+WORDS+1.
- Key path:
  - Accept at T, go to KEY_SUB.
  - At T+1: sbox_data_o = captured word, result registered.
  - key_valid_o rises at T+2 (KEY_OUT).
- Output handshake:
  - valid stays high and data stays stable until the matching ready_i is sampled high. On that edge, valid drops and the state returns to IDLE.
  - A new request can be accepted in the cycle after the handshake, not in the same cycle.
- sbox_data_o = 0 outside BLK_SUB and KEY_SUB.
- Data registers hold their last value after the handshake; valid outputs are the only qualifiers.
- Index rolls over from WORDS-1 to 0 on the last word; there is no state for the index beyond WORDS-1.
- Throughput at default parameters: one block per 6 cycles minimum, one key word per 3 cycles minimum.

Test Plan:
- Reset, then idle: all outputs 0; blk_ready_o=1 and key_ready_o=1 with no valids asserted.
- Block request 0x000102030405060708090a0b0c0d0e0f accepted at T, bench S-box attached, blk_ready_i=1 -> blk_valid_o high at T+5 only, blk_data_o=0x637c777bf26b6fc53001672bfed7ab76.
- Key request 0x53ff0001 -> key_valid_o at T+2, key_data_o=0xed16637c.
- blk_valid_i and key_valid_i asserted together and held from reset -> key served first, then block, then key: grants alternate and busy_o is never low for more than 1 cycle between grants.
- Backpressure: blk_ready_i low for 10 cycles after blk_valid_o -> blk_valid_o and data held stable, key_ready_o=0 throughout; release -> IDLE next cycle.
- rst_ni pulsed low during BLK_SUB (index 2) -> outputs 0 immediately; no blk_valid_o after release; the next request completes correctly.
